// File: rtl/pulse_emitter.sv
// Turns single-cycle triggers into fixed-width level pulses with a guaranteed low gap,
// sized for a far-domain 2-flop synchronizer; extra triggers queue in a saturating counter.
module pulse_emitter #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig_in,
    input  logic              clear,
    output logic              pulse_level,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic              done
);

    localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;
    logic              pulse_level_q, pulse_level_d;
    logic              start_from_trig;
    logic              dequeue;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pending_d       = pending_q;
        overflow_d      = overflow_q;
        done_d          = 1'b0;
        start_from_trig = 1'b0;
        dequeue         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig_in) begin
                    state_d         = S_HIGH;
                    cnt_d           = HIGH_LOAD;
                    start_from_trig = 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_LOW;
                    cnt_d   = LOW_LOAD;
                end
            end
            S_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    done_d = 1'b1;
                    // Queued work takes precedence; a fresh trigger only starts directly on an empty queue.
                    if (pending_q != '0) begin
                        state_d = S_HIGH;
                        cnt_d   = HIGH_LOAD;
                        dequeue = 1'b1;
                    end else if (trig_in) begin
                        state_d         = S_HIGH;
                        cnt_d           = HIGH_LOAD;
                        start_from_trig = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (trig_in && !start_from_trig) begin
            if (!dequeue) begin
                if (pending_q != PEND_MAX) begin
                    pending_d = pending_q + PEND_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end else if (dequeue) begin
            pending_d = pending_q - PEND_W'(1);
        end

        if (clear) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            pending_d  = '0;
            overflow_d = 1'b0;
            done_d     = 1'b0;
        end

        pulse_level_d = (state_d == S_HIGH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pending_q     <= '0;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
            pulse_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            done_q        <= done_d;
            pulse_level_q <= pulse_level_d;
        end
    end

    assign pulse_level = pulse_level_q;
    assign busy        = (state_q != S_IDLE);
    assign pending     = pending_q;
    assign overflow    = overflow_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pulse_emitter.sv
// Scoreboard bench for pulse_emitter: a schedule-of-pulse-start-times model predicts every
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_pulse_emitter;

    localparam int H      = 4;
    localparam int L      = 4;
    localparam int PEND_W = 2;
    localparam int PMAX   = (1 << PEND_W) - 1;
    localparam int PER    = H + L;
    localparam int NEVER  = 1 << 30;

    typedef struct {
        int              edge_no;
        logic            pl;
        logic            busy;
        logic [PEND_W-1:0] pend;
        logic            ovf;
        logic            done;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trig_in;
    logic              clear;
    logic              pulse_level;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;
    logic              done;

    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Model: start edge of every scheduled pulse, and the edge a clear cut it short.
    int st_q[$];
    int cut_q[$];
    int free_at;
    bit m_ovf;

    pulse_emitter #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .PEND_W(PEND_W)) dut (
        .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .clear(clear),
        .pulse_level(pulse_level), .busy(busy), .pending(pending),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic checkOutput(input string name, input logic pl, input logic b,
                               input logic [PEND_W-1:0] p, input logic o, input logic d);
        tests++;
        if (pulse_level !== pl || busy !== b || pending !== p || overflow !== o || done !== d) begin
            fails++;
            $display("[TB] FAIL %s: got pl=%b busy=%b pend=%0d ovf=%b done=%b, want pl=%b busy=%b pend=%0d ovf=%b done=%b",
                     name, pulse_level, busy, pending, overflow, done, pl, b, p, o, d);
        end
    endtask

    function automatic int count_after(input int t);
        int n = 0;
        foreach (st_q[i]) if (st_q[i] > t) n++;
        return n;
    endfunction

    task automatic model_reset();
        st_q.delete();
        cut_q.delete();
        free_at = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input int t, input logic trg, input logic clr);
        exp_t e;
        int   pend;
        int   s;
        int   c;
        while (st_q.size() > 0 && st_q[0] + PER < t - 2) begin
            void'(st_q.pop_front());
            void'(cut_q.pop_front());
        end
        if (clr) begin
            while (st_q.size() > 0 && st_q[st_q.size()-1] >= t) begin
                void'(st_q.pop_back());
                void'(cut_q.pop_back());
            end
            foreach (cut_q[i]) if (cut_q[i] > t) cut_q[i] = t;
            free_at = t + 1;
            m_ovf   = 1'b0;
        end else if (trg) begin
            pend = count_after(t);
            if (pend == 0 && t >= free_at) begin
                st_q.push_back(t);
                cut_q.push_back(NEVER);
                free_at = t + PER;
            end else if (pend < PMAX) begin
                st_q.push_back(free_at);
                cut_q.push_back(NEVER);
                free_at = free_at + PER;
            end else begin
                m_ovf = 1'b1;
            end
        end
        e.edge_no = t;
        e.pl      = 1'b0;
        e.busy    = 1'b0;
        e.done    = 1'b0;
        foreach (st_q[i]) begin
            s = st_q[i];
            c = cut_q[i];
            if (s <= t && t < s + H && t < c)   e.pl   = 1'b1;
            if (s <= t && t < s + PER && t < c) e.busy = 1'b1;
            if (t == s + PER && c > t)          e.done = 1'b1;
        end
        e.pend = PEND_W'(count_after(t));
        e.ovf  = m_ovf;
        exp_q.push_back(e);
    endtask

    // Called between posedge+1 and the next posedge; returns at posedge+1.
    task automatic applyStimulus(input logic t_in, input logic c_in);
        trig_in = t_in;
        clear   = c_in;
        model_step(edge_cnt + 1, t_in, c_in);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic doAsyncReset();
        #6;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        mon_en = 1'b0;
        exp_q.delete();
        model_reset();
        trig_in = 1'b0;
        clear   = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            if (exp_q[0].edge_no < edge_cnt) begin
                tests++;
                fails++;
                $display("[TB] FAIL missed_check: got edge %0d, want edge %0d", edge_cnt, exp_q[0].edge_no);
                void'(exp_q.pop_front());
            end else if (exp_q[0].edge_no == edge_cnt) begin
                mon_e = exp_q.pop_front();
                checkOutput($sformatf("edge%0d", mon_e.edge_no),
                            mon_e.pl, mon_e.busy, mon_e.pend, mon_e.ovf, mon_e.done);
            end
        end
    end

    initial begin
        int prob;
        rst_n   = 1'b0;
        trig_in = 1'b0;
        clear   = 1'b0;
        model_reset();
        #3;
        checkOutput("reset_state", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Single trigger from idle.
        applyStimulus(1'b1, 1'b0);
        idle(12);

        // Three back-to-back triggers.
        repeat (3) applyStimulus(1'b1, 1'b0);
        idle(30);

        // Saturation: one starts, three queue, two are dropped.
        repeat (6) applyStimulus(1'b1, 1'b0);
        idle(40);
        applyStimulus(1'b0, 1'b1);
        idle(2);

        // Trigger exactly on the end of LOW with nothing queued.
        applyStimulus(1'b1, 1'b0);
        idle(7);
        applyStimulus(1'b1, 1'b0);
        idle(20);

        // Trigger on the dequeue edge with two queued.
        repeat (3) applyStimulus(1'b1, 1'b0);
        idle(5);
        applyStimulus(1'b1, 1'b0);
        idle(35);

        // Clear with trigger in the second cycle of a dequeued HIGH, overflow set.
        repeat (5) applyStimulus(1'b1, 1'b0);
        idle(4);
        applyStimulus(1'b1, 1'b1);
        idle(20);

        // Async reset in the middle of LOW, then a fresh trigger.
        applyStimulus(1'b1, 1'b0);
        idle(5);
        doAsyncReset();
        idle(3);
        applyStimulus(1'b1, 1'b0);
        idle(12);

        // Randomized traffic at varying trigger densities.
        for (int blk = 0; blk < 8; blk++) begin
            case (blk % 4)
                0: prob = 10;
                1: prob = 30;
                2: prob = 60;
                default: prob = 95;
            endcase
            if (blk == 5) doAsyncReset();
            for (int i = 0; i < 100; i++) begin
                applyStimulus(($urandom_range(99) < prob) ? 1'b1 : 1'b0,
                              ($urandom_range(49) == 0) ? 1'b1 : 1'b0);
            end
        end
        idle(40);

        #6;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
